// File: rtl/nios2_jtag_scan_master.sv
// nios2_jtag_scan_master: host-side JTAG TAP driver issuing IR/DR scans; define NIOS2_JTAG_SCAN_RTI_EN for a Run-Test/Idle wait after each scan
module nios2_jtag_scan_master #(
    parameter int TCK_DIV = 2,
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_tlr,
    input  logic               cmd_ir,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
`ifdef NIOS2_JTAG_SCAN_RTI_EN
    input  logic [7:0]         rti_cycles,
`endif
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);
    localparam logic [2:0] TLR_SEQ  = 3'd0;
    localparam logic [2:0] IDLE     = 3'd1;
    localparam logic [2:0] PRE      = 3'd2;
    localparam logic [2:0] SHIFT    = 3'd3;
    localparam logic [2:0] POST     = 3'd4;
    localparam logic [2:0] RTI_WAIT = 3'd5;
    localparam logic [2:0] RESP     = 3'd6;
    localparam int IW = (LEN_W > 8) ? LEN_W : 8;
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic [2:0]         state, adv_state, nst;
    logic [IW-1:0]      idx, nidx, nbits;
    logic [CW-1:0]      cnt;
    logic               ir_q, tlr_q, tick, last, ntms, ntdi, bad_len;
    logic [LEN_W-1:0]   len_q;
    logic [MAX_LEN-1:0] data_q;
    logic [7:0]         rti_q;

`ifndef NIOS2_JTAG_SCAN_RTI_EN
    assign rti_q = 8'd0;
`endif

    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;

    // Each running state is a list of TCK periods; work out the bit that follows the current one
    always_comb begin
        tick      = cnt == CW'(TCK_DIV - 1);
        bad_len   = cmd_len == '0 || cmd_len > LEN_W'(MAX_LEN);
        nbits     = state == TLR_SEQ ? IW'(6) :
                    state == PRE     ? (ir_q ? IW'(4) : IW'(3)) :
                    state == SHIFT   ? IW'(len_q) :
                    state == POST    ? IW'(2) : IW'(rti_q);
        last      = idx == nbits - IW'(1);
        adv_state = state == TLR_SEQ ? (tlr_q ? RESP : IDLE) :
                    state == PRE     ? SHIFT :
                    state == SHIFT   ? POST :
                    state == POST    ? (rti_q != 8'd0 ? RTI_WAIT : RESP) : RESP;
        nst       = last ? adv_state : state;
        nidx      = last ? '0 : idx + IW'(1);
        ntms      = nst == TLR_SEQ ? nidx < IW'(5) :
                    nst == PRE     ? (ir_q ? nidx < IW'(2) : nidx == '0) :
                    nst == SHIFT   ? nidx == IW'(len_q) - IW'(1) :
                    nst == POST    ? nidx == '0 : 1'b0;
        ntdi      = nst == SHIFT && data_q[nidx[AW-1:0]];
    end

    // Command accept, TCK divider, tms/tdi launch on falling TCK, tdo capture on rising TCK, response hold
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= TLR_SEQ;
            idx       <= '0;
            cnt       <= '0;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            tlr_q     <= 1'b0;
            ir_q      <= 1'b0;
            len_q     <= '0;
            data_q    <= '0;
`ifdef NIOS2_JTAG_SCAN_RTI_EN
            rti_q     <= 8'd0;
`endif
        end else if (state == IDLE) begin
            if (cmd_valid) begin
                tlr_q    <= cmd_tlr;
                ir_q     <= cmd_ir;
                len_q    <= cmd_len;
                data_q   <= cmd_data;
`ifdef NIOS2_JTAG_SCAN_RTI_EN
                rti_q    <= rti_cycles;
`endif
                cnt      <= '0;
                idx      <= '0;
                tdi      <= 1'b0;
                rsp_data <= '0;
                rsp_err  <= !cmd_tlr && bad_len;
                if (cmd_tlr || !bad_len)
                    tms <= 1'b1;
                state    <= cmd_tlr ? TLR_SEQ : bad_len ? RESP : PRE;
            end
        end else if (state == RESP) begin
            if (!rsp_valid)
                rsp_valid <= 1'b1;
            else if (rsp_ready) begin
                rsp_valid <= 1'b0;
                state     <= IDLE;
            end
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                tck <= !tck;
                if (tck) begin
                    state <= nst;
                    idx   <= nidx;
                    tms   <= ntms;
                    tdi   <= ntdi;
                end else if (state == SHIFT)
                    rsp_data[idx[AW-1:0]] <= tdo;
            end
        end
    end
endmodule

// File: tb/tb_nios2_jtag_scan_master.sv
// tb_nios2_jtag_scan_master: randomized scans against a behavioural JTAG TAP model
`timescale 1ns/1ps
module tb_nios2_jtag_scan_master;
    localparam int TCK_DIV = 2;

    logic        clk = 1'b0, reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_tlr = 1'b0, cmd_ir = 1'b0, rsp_ready = 1'b0;
    logic [6:0]  cmd_len = '0;
    logic [63:0] cmd_data = '0;
    logic        cmd_ready, rsp_valid, rsp_err, busy, tck, tms, tdi, tdo;
    logic [63:0] rsp_data;
`ifdef NIOS2_JTAG_SCAN_RTI_EN
    logic [7:0]  rti_cycles = 8'd0;
`endif
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    nios2_jtag_scan_master #(.TCK_DIV(TCK_DIV), .MAX_LEN(64), .LEN_W(7)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_tlr(cmd_tlr), .cmd_ir(cmd_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
`ifdef NIOS2_JTAG_SCAN_RTI_EN
        .rti_cycles(rti_cycles),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    // IEEE 1149.1 TAP controller model with a 64-bit capture/shift path
    typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PSDR, EX2DR, UPDR,
                              SELIR, CAPIR, SHIR, EX1IR, PSIR, EX2IR, UPIR} tap_t;
    tap_t        tap = SHDR;
    logic [63:0] sr = '0, dr_pre = '0, dr_upd = '0, ir_upd = '0, tms_hist = '0;
    int          shifts = 0, rises = 0;

    assign tdo = (tap == SHDR || tap == SHIR) ? sr[0] : 1'b0;

    function automatic tap_t tap_next(tap_t s, logic m);
        case (s)
            TLR:            return m ? TLR : RTI;
            RTI, UPDR, UPIR: return m ? SELDR : RTI;
            SELDR:          return m ? SELIR : CAPDR;
            CAPDR, SHDR:    return m ? EX1DR : SHDR;
            EX1DR:          return m ? UPDR : PSDR;
            PSDR:           return m ? EX2DR : PSDR;
            EX2DR:          return m ? UPDR : SHDR;
            SELIR:          return m ? TLR : CAPIR;
            CAPIR, SHIR:    return m ? EX1IR : SHIR;
            EX1IR:          return m ? UPIR : PSIR;
            PSIR:           return m ? EX2IR : PSIR;
            default:        return m ? UPIR : SHIR;
        endcase
    endfunction

    always @(posedge tck) begin
        rises    <= rises + 1;
        tms_hist <= {tms_hist[62:0], tms};
        if (tap == CAPDR) begin
            sr <= dr_pre;
            shifts <= 0;
        end else if (tap == CAPIR) begin
            sr <= 64'd1;
            shifts <= 0;
        end else if (tap == SHDR || tap == SHIR) begin
            sr <= {tdi, sr[63:1]};
            shifts <= shifts + 1;
        end
        if (tap == UPDR) dr_upd <= sr >> (64 - shifts);
        if (tap == UPIR) ir_upd <= sr >> (64 - shifts);
        tap <= tap_next(tap, tms);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mask(input int n);
        return n >= 64 ? '1 : (64'd1 << n) - 64'd1;
    endfunction

    task automatic wait_ready();
        int k = 0;
        while (!cmd_ready && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        if (!cmd_ready) check("ready_timeout", {63'd0, cmd_ready}, 64'd1);
    endtask

    // Issue one command, then check response, TCK count, latency and TAP-side effects
    task automatic do_cmd(input logic tlr, input logic ir, input int len, input logic [63:0] data);
        int k, r0, ntck;
        logic bad;
        logic [63:0] exp_data;
        wait_ready();
        bad = !tlr && (len == 0 || len > 64);
        ntck = tlr ? 6 : bad ? 0 : ir ? len + 6 : len + 5;
        exp_data = (tlr || bad) ? 64'd0 : ir ? (64'd1 & mask(len)) : (dr_pre & mask(len));
        cmd_tlr = tlr; cmd_ir = ir; cmd_len = 7'(len); cmd_data = data; cmd_valid = 1'b1;
        r0 = rises;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_data = {$urandom, $urandom}; cmd_len = 7'($urandom); cmd_ir = 1'($urandom);
        k = 0;
        while (!rsp_valid && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("latency", 64'(k), 64'(ntck * 2 * TCK_DIV + 1));
        check("tck_count", 64'(rises - r0), 64'(ntck));
        check("rsp_data", rsp_data, exp_data);
        check("rsp_err", {63'd0, rsp_err}, {63'd0, bad});
        if (!bad) check("tap_rti", 64'(tap), 64'(RTI));
        if (!tlr && !bad) check(ir ? "ir_update" : "dr_update", ir ? ir_upd : dr_upd, data & mask(len));
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("ack_ready", {63'd0, cmd_ready}, 64'd1);
        check("ack_valid", {63'd0, rsp_valid}, 64'd0);
    endtask

    initial begin
        int r0, hs, sel, len;
        logic hs_next;
        logic [63:0] held;
        repeat (4) @(posedge clk);
        #1;
        check("rst_tck", {63'd0, tck}, 64'd0);
        check("rst_tms", {63'd0, tms}, 64'd1);
        check("rst_ready", {63'd0, cmd_ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd1);
        check("rst_valid", {63'd0, rsp_valid}, 64'd0);
        r0 = rises;
        reset = 1'b0;
        wait_ready();
        check("tlr_rises", 64'(rises - r0), 64'd6);
        check("tlr_tms", tms_hist & mask(6), 64'b111110);
        check("tlr_tap", 64'(tap), 64'(RTI));
        check("tlr_valid", {63'd0, rsp_valid}, 64'd0);

        dr_pre = 64'h3C;
        do_cmd(1'b0, 1'b0, 8, 64'hA5);
        check("dr_tms", tms_hist & mask(13), 64'b1_0000_0000_0110 | (64'b100 << 10));
        held = rsp_data;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("hold_valid", {63'd0, rsp_valid}, 64'd1);
            check("hold_data", rsp_data, held);
            check("hold_ready", {63'd0, cmd_ready}, 64'd0);
        end
        ack();

        do_cmd(1'b0, 1'b1, 2, 64'h2);
        check("ir_tms", tms_hist & mask(8), 64'b11000110);
        ack();

        do_cmd(1'b0, 1'b0, 0, 64'hFF);
        ack();
        do_cmd(1'b0, 1'b0, 65, 64'hFF);
        ack();
        do_cmd(1'b1, 1'b0, 3, 64'h5);
        check("tlrcmd_tms", tms_hist & mask(6), 64'b111110);
        ack();
        dr_pre = {$urandom, $urandom};
        do_cmd(1'b0, 1'b0, 1, 64'h1);
        check("len1_tms", tms_hist & mask(6), 64'b100110);
        ack();
        do_cmd(1'b0, 1'b0, 64, {$urandom, $urandom});
        ack();

        for (int i = 0; i < 25; i++) begin
            sel = $urandom_range(0, 9);
            dr_pre = {$urandom, $urandom};
            len = sel == 0 ? ($urandom_range(0, 1) == 0 ? 0 : $urandom_range(65, 127)) :
                  sel == 2 ? 1 : sel == 3 ? 64 : $urandom_range(1, 64);
            do_cmd(sel == 1, 1'($urandom), len, {$urandom, $urandom});
            ack();
        end

        wait_ready();
        dr_pre = {$urandom, $urandom};
        cmd_tlr = 1'b0; cmd_ir = 1'b0; cmd_len = 7'd64; cmd_data = {$urandom, $urandom}; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("mid_tap_shift", 64'(tap), 64'(SHDR));
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_tck", {63'd0, tck}, 64'd0);
        check("mid_rst_tms", {63'd0, tms}, 64'd1);
        check("mid_rst_valid", {63'd0, rsp_valid}, 64'd0);
        check("mid_rst_ready", {63'd0, cmd_ready}, 64'd0);
        r0 = rises;
        reset = 1'b0;
        wait_ready();
        check("mid_tlr_rises", 64'(rises - r0), 64'd6);
        check("mid_tlr_tap", 64'(tap), 64'(RTI));
        do_cmd(1'b0, 1'b0, 16, {$urandom, $urandom});
        ack();

        wait_ready();
        cmd_tlr = 1'b0; cmd_len = 7'd0; cmd_valid = 1'b1; rsp_ready = 1'b1;
        hs = 0; hs_next = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (hs_next) begin
                hs++;
                check("b2b_ready", {63'd0, cmd_ready}, 64'd1);
            end
            hs_next = rsp_valid && rsp_ready;
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        check("b2b_count", 64'(hs), 64'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
